// File: rtl/rs_pulse_driver_if.sv
// rs_pulse_driver_if
//   Button and latch-drive bundle for rs_pulse_driver.
//   set_btn, clr_btn : raw active-high push buttons (master -> slave)
//   s, r             : active-low latch set/reset pulses (slave -> master)
//   busy             : pulse or gap in progress (slave -> master)
interface rs_pulse_driver_if;
    logic set_btn;
    logic clr_btn;
    logic s;
    logic r;
    logic busy;

    modport master (output set_btn, output clr_btn, input s, input r, input busy);
    modport slave  (input set_btn, input clr_btn, output s, output r, output busy);
endinterface

// File: rtl/rs_pulse_driver.sv
// rs_pulse_driver
//   Debounces two raw push buttons and turns each accepted press into a
//   fixed-width active-low pulse on s (set) or r (clear) for an RS latch.
//   s and r are never low together; clear wins when both are pending.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : rs_pulse_driver_if.slave (set_btn, clr_btn in; s, r, busy out)
// Parameters:
//   DEBOUNCE_CYCLES : consecutive stable samples to accept a level change
//   PULSE_CYCLES    : width of each low pulse
// Build option:
//   RS_PULSE_SYNC_EN : when defined, each button passes a 2-flop
//                      synchronizer before the debouncer.
module rs_pulse_driver #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSE_CYCLES    = 2
) (
    input  logic               clk,
    input  logic               rst,
    rs_pulse_driver_if.slave   bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PW = $clog2(PULSE_CYCLES + 1);
    localparam int NB = 2;   // bit 0 = set button, bit 1 = clear button

    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] PC_LAST  = PW'(PULSE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SET, CLR, GAP} state_t;

    logic [NB-1:0]         raw;
    logic [NB-1:0]         sb;
    logic [NB-1:0]         deb;
    logic [NB-1:0][CW-1:0] cnt;
    logic [NB-1:0]         rise;
    logic [NB-1:0]         pend;
    logic [NB-1:0]         pend_clr;

    state_t          state, state_nxt;
    logic [PW-1:0]   pc, pc_nxt;
    logic            s_q, r_q, busy_q;
    logic            s_nxt, r_nxt, busy_nxt;

    assign raw = {bus.clr_btn, bus.set_btn};

`ifdef RS_PULSE_SYNC_EN
    logic [NB-1:0] sync1, sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    assign sb = sync2;
`else
    assign sb = raw;
`endif

    // Debouncer: a level change is accepted only after DEBOUNCE_CYCLES
    // consecutive mismatching samples; any matching sample restarts the run.
    always_ff @(posedge clk) begin
        if (rst) begin
            deb <= '0;
            cnt <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (sb[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    deb[i] <= sb[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // Press = the edge on which deb is about to go 0 -> 1.
    always_comb begin
        rise = '0;
        for (int i = 0; i < NB; i++)
            rise[i] = sb[i] & ~deb[i] & (cnt[i] == CNT_LAST);
    end

    // One-deep pending flags; a new press on the same edge as the FSM
    // consuming the old one is kept.
    always_ff @(posedge clk) begin
        if (rst) pend <= '0;
        else     pend <= (pend & ~pend_clr) | rise;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            pc     <= '0;
            s_q    <= 1'b1;
            r_q    <= 1'b1;
            busy_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            pc     <= pc_nxt;
            s_q    <= s_nxt;
            r_q    <= r_nxt;
            busy_q <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        s_nxt     = s_q;
        r_nxt     = r_q;
        pend_clr  = '0;
        case (state)
            IDLE: begin
                // Only one output is ever dropped here, so s/r never overlap.
                if (pend[1]) begin
                    state_nxt   = CLR;
                    pend_clr[1] = 1'b1;
                    r_nxt       = 1'b0;
                    pc_nxt      = '0;
                end else if (pend[0]) begin
                    state_nxt   = SET;
                    pend_clr[0] = 1'b1;
                    s_nxt       = 1'b0;
                    pc_nxt      = '0;
                end
            end
            SET, CLR: begin
                if (pc == PC_LAST) begin
                    state_nxt = GAP;
                    s_nxt     = 1'b1;
                    r_nxt     = 1'b1;
                end else begin
                    pc_nxt = pc + PW'(1);
                end
            end
            GAP: begin
                state_nxt = IDLE;
                s_nxt     = 1'b1;
                r_nxt     = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
                s_nxt     = 1'b1;
                r_nxt     = 1'b1;
            end
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    assign bus.s    = s_q;
    assign bus.r    = r_q;
    assign bus.busy = busy_q;
endmodule

// File: tb/tb_rs_pulse_driver.sv
// tb_rs_pulse_driver
//   Scoreboard bench: each scenario pushes the expected per-cycle
//   {s, r, busy} trace derived from the documented latencies, then drives
//   the buttons; every cycle one entry is popped and compared.
module tb_rs_pulse_driver;
    localparam int DEB = 4;
    localparam int PUL = 2;
`ifdef RS_PULSE_SYNC_EN
    localparam int LAT = DEB + 2;
`else
    localparam int LAT = DEB;
`endif

    localparam logic [2:0] O_IDLE = 3'b110;  // {s, r, busy}
    localparam logic [2:0] O_SLOW = 3'b011;
    localparam logic [2:0] O_RLOW = 3'b101;
    localparam logic [2:0] O_GAP  = 3'b111;

    logic clk = 1'b0;
    logic rst = 1'b1;

    rs_pulse_driver_if bus ();

    rs_pulse_driver #(
        .DEBOUNCE_CYCLES (DEB),
        .PULSE_CYCLES    (PUL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;
    logic [2:0] expq[$];

    task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %b expected %b at t=%0t", tag, got, exp, $time);
        end
    endtask

    // s and r low together is never allowed, reset included.
    always @(negedge clk) chk("no_both_low", {2'b00, bus.s | bus.r}, 3'b001);

    task automatic push_idle(input int n);
        repeat (n) expq.push_back(O_IDLE);
    endtask

    task automatic push_pulse(input bit is_set);
        repeat (PUL) expq.push_back(is_set ? O_SLOW : O_RLOW);
        expq.push_back(O_GAP);
    endtask

    task automatic run(input int n, input string tag);
        logic [2:0] e;
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            // An empty queue yields an impossible expectation so it is flagged.
            e = (expq.size() > 0) ? expq.pop_front() : 3'b000;
            chk(tag, {bus.s, bus.r, bus.busy}, e);
        end
    endtask

    initial begin
        bus.set_btn = 1'b1;
        bus.clr_btn = 1'b1;
        rst = 1'b1;

        // Reset held 3 cycles with both buttons high.
        push_idle(3);
        run(3, "reset");
        rst = 1'b0;

        // Buttons already high at release: simultaneous press, clear first.
        push_idle(LAT);
        push_pulse(1'b0);
        push_idle(1);
        push_pulse(1'b1);
        push_idle(2);
        run(LAT + 3 + 1 + 3 + 2, "simul");

        bus.set_btn = 1'b0;
        bus.clr_btn = 1'b0;
        push_idle(LAT + 3);
        run(LAT + 3, "release");

        // Clean set press.
        bus.set_btn = 1'b1;
        push_idle(LAT);
        push_pulse(1'b1);
        push_idle(3);
        run(LAT + 6, "set_press");
        bus.set_btn = 1'b0;
        push_idle(LAT + 2);
        run(LAT + 2, "set_release");

        // Bounce: high runs of 3 and 2 rejected, run of 6 accepted.
        push_idle(9);
        bus.set_btn = 1'b1; run(3, "bounce3");
        bus.set_btn = 1'b0; run(2, "bounce_lo");
        bus.set_btn = 1'b1; run(2, "bounce2");
        bus.set_btn = 1'b0; run(2, "bounce_lo");
        push_idle(LAT);
        push_pulse(1'b1);
        push_idle(8);
        bus.set_btn = 1'b1; run(6, "bounce6");
        bus.set_btn = 1'b0; run(LAT + 3 + 8 - 6, "bounce_tail");

        // Clear pressed while the set pulse is low: serviced after GAP + IDLE.
        push_idle(LAT);
        push_pulse(1'b1);
        push_idle(1);
        push_pulse(1'b0);
        push_idle(4);
        bus.set_btn = 1'b1;
        run(2, "during_pulse");
        bus.clr_btn = 1'b1;
        run(LAT + 3 + 1 + 3 + 4 - 2, "during_pulse");
        bus.set_btn = 1'b0;
        bus.clr_btn = 1'b0;
        push_idle(LAT + 3);
        run(LAT + 3, "release2");

        // Reset during the first low cycle of s, with a clear press pending.
        push_idle(LAT);
        expq.push_back(O_SLOW);
        bus.set_btn = 1'b1;
        run(1, "mid_rst_pre");
        bus.clr_btn = 1'b1;
        run(LAT, "mid_rst_pre");
        rst = 1'b1;
        bus.set_btn = 1'b0;
        bus.clr_btn = 1'b0;
        push_idle(2);
        run(2, "mid_rst");
        rst = 1'b0;
        push_idle(LAT + 6);
        run(LAT + 6, "after_rst");

        chk("drain", 3'(expq.size()), 3'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
